// File: rtl/puf_seq_pkg.sv
// puf_seq_pkg
// Shared definitions for the arbiter-PUF evaluation sequencer:
//   - seq_state_t : FSM state encoding
//   - DEF_*       : default timing/width constants used as parameter defaults
//   - LFSR_POLY / LFSR_SEED and lfsr_step() : challenge generator used when
//     the design is built with PUF_SEQ_LFSR_EN
package puf_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FIRE,
    ST_CAPTURE,
    ST_DONE
  } seq_state_t;

  localparam int DEF_CHAL_W      = 16;
  localparam int DEF_SETTLE_CYC  = 4;
  localparam int DEF_PULSE_CYC   = 2;
  localparam int DEF_CAPTURE_CYC = 4;
  localparam int DEF_REP_W       = 4;

  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// puf_resp_sync
// Two-flop synchronizer bringing the free-running PUF response into the
// sequencer clock domain. Both flops clear on reset.
// Ports:
//   clk : sampling clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input (PUF oresponse)
//   q   : synchronized output
module puf_resp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_eval_sequencer.sv
// puf_eval_sequencer
// Accepts one challenge per request, fires the arbiter PUF (req_repeats+1)
// times, majority-votes the sampled response bits and reports the vote,
// the count of ones and whether the samples disagreed.
// Optional build macro: PUF_SEQ_LFSR_EN adds req_lfsr_mode, which takes the
// challenge from an internal 16-bit Galois LFSR instead of req_challenge.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, async active-high reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_challenge, req_repeats  : captured on request handshake
//   puf_pulse, puf_challenge    : registered drives to the PUF core
//   puf_response                : PUF output, asynchronous
//   rsp_valid/rsp_ready         : result handshake (valid only in DONE)
//   rsp_bit, rsp_ones, rsp_unstable : vote, ones count, disagreement flag
module puf_eval_sequencer
  import puf_seq_pkg::*;
#(
  parameter int CHAL_W      = DEF_CHAL_W,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int PULSE_CYC   = DEF_PULSE_CYC,
  parameter int CAPTURE_CYC = DEF_CAPTURE_CYC,
  parameter int REP_W       = DEF_REP_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAL_W-1:0] req_challenge,
  input  logic [REP_W-1:0]  req_repeats,
`ifdef PUF_SEQ_LFSR_EN
  input  logic              req_lfsr_mode,
`endif
  output logic              puf_pulse,
  output logic [CHAL_W-1:0] puf_challenge,
  input  logic              puf_response,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bit,
  output logic [REP_W:0]    rsp_ones,
  output logic              rsp_unstable
);

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] PULSE_LAST   = 8'(PULSE_CYC - 1);
  localparam logic [7:0] CAPTURE_LAST = 8'(CAPTURE_CYC - 1);

  seq_state_t        state;
  logic [7:0]        phase_cnt;
  logic [REP_W-1:0]  eval_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W:0]    ones_cnt;
  logic              resp_sync;
  logic [CHAL_W-1:0] chal_sel;
  logic [REP_W:0]    ones_next;
  logic [REP_W:0]    eval_total;
  logic              vote_bit;
  logic              vote_unstable;

  puf_resp_sync u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (puf_response),
    .q   (resp_sync)
  );

`ifdef PUF_SEQ_LFSR_EN
  logic [15:0] lfsr_q;

  // Advances only when an LFSR-mode request is actually accepted
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (state == ST_IDLE && req_valid && req_lfsr_mode) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign chal_sel = req_lfsr_mode ? CHAL_W'(lfsr_q) : req_challenge;
`else
  assign chal_sel = req_challenge;
`endif

  // Vote terms include the sample taken this cycle, so the result is final
  // on the same edge that enters DONE. A tie (2*ones == N) votes 0.
  assign ones_next     = ones_cnt + {{REP_W{1'b0}}, resp_sync};
  assign eval_total    = {1'b0, rep_cnt} + 1'b1;
  assign vote_bit      = ({ones_next, 1'b0} > {1'b0, eval_total});
  assign vote_unstable = (ones_next != '0) && (ones_next != eval_total);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      phase_cnt     <= '0;
      eval_cnt      <= '0;
      rep_cnt       <= '0;
      ones_cnt      <= '0;
      req_ready     <= 1'b1;
      puf_pulse     <= 1'b0;
      puf_challenge <= '0;
      rsp_valid     <= 1'b0;
      rsp_bit       <= 1'b0;
      rsp_ones      <= '0;
      rsp_unstable  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            puf_challenge <= chal_sel;
            rep_cnt       <= req_repeats;
            eval_cnt      <= '0;
            ones_cnt      <= '0;
            phase_cnt     <= '0;
            req_ready     <= 1'b0;
            state         <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            phase_cnt <= '0;
            puf_pulse <= 1'b1;
            state     <= ST_FIRE;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        ST_FIRE: begin
          if (phase_cnt == PULSE_LAST) begin
            phase_cnt <= '0;
            puf_pulse <= 1'b0;
            state     <= ST_CAPTURE;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        ST_CAPTURE: begin
          if (phase_cnt == CAPTURE_LAST) begin
            phase_cnt <= '0;
            ones_cnt  <= ones_next;
            if (eval_cnt == rep_cnt) begin
              rsp_valid    <= 1'b1;
              rsp_ones     <= ones_next;
              rsp_bit      <= vote_bit;
              rsp_unstable <= vote_unstable;
              state        <= ST_DONE;
            end else begin
              eval_cnt <= eval_cnt + 1'b1;
              state    <= ST_SETTLE;
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// tb_puf_eval_sequencer
// Directed bench for puf_eval_sequencer with a scoreboard: every accepted
// request pushes its hand-computed result into exp_q, and an independent
// monitor pops and compares when rsp_valid rises. A small PUF model returns
// a scripted bit per pulse. Build with PUF_SEQ_LFSR_EN to include the LFSR
// challenge checks.
module tb_puf_eval_sequencer;

  localparam int EVAL_CYC = 10;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_challenge;
  logic [3:0]  req_repeats;
`ifdef PUF_SEQ_LFSR_EN
  logic        req_lfsr_mode;
`endif
  logic        puf_pulse;
  logic [15:0] puf_challenge;
  logic        puf_response;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_bit;
  logic [4:0]  rsp_ones;
  logic        rsp_unstable;

  typedef struct {
    logic [15:0] chal;
    logic        bit_v;
    logic [4:0]  ones;
    logic        unstable;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic resp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  puf_eval_sequencer dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_challenge (req_challenge),
    .req_repeats   (req_repeats),
`ifdef PUF_SEQ_LFSR_EN
    .req_lfsr_mode (req_lfsr_mode),
`endif
    .puf_pulse     (puf_pulse),
    .puf_challenge (puf_challenge),
    .puf_response  (puf_response),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_bit       (rsp_bit),
    .rsp_ones      (rsp_ones),
    .rsp_unstable  (rsp_unstable)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, actual, expected, cyc);
  endtask

  // PUF model: each rising pulse produces the next scripted response bit
  always @(posedge puf_pulse) begin
    #2;
    puf_response = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
  end

  // Monitor: compares each new result against the oldest expectation
  always @(negedge wb_clk_i) begin
    if (rsp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 expected no result (cyc %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rsp_bit", 32'(rsp_bit), 32'(mon_e.bit_v));
        checkOutput("rsp_ones", 32'(rsp_ones), 32'(mon_e.ones));
        checkOutput("rsp_unstable", 32'(rsp_unstable), 32'(mon_e.unstable));
        checkOutput("rsp_challenge", 32'(puf_challenge), 32'(mon_e.chal));
        checkOutput("rsp_latency", 32'(cyc), 32'(mon_e.due));
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic issueRequest(input logic [15:0] chal, input logic [3:0] reps,
                              input logic [15:0] bits, input logic eb,
                              input logic [4:0] eo, input logic eu,
                              input logic [15:0] echal, output int hs);
    exp_t e;
    for (int i = 0; i <= int'(reps); i++) resp_q.push_back(bits[i]);
    @(negedge wb_clk_i);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_challenge = chal;
    req_repeats   = reps;
    req_valid     = 1'b1;
    @(posedge wb_clk_i);
    #1;
    hs = cyc;
    req_valid = 1'b0;
    // rsp_valid is first visible in cycle N*10+1, i.e. N*10 edges after the handshake edge
    e.chal = echal; e.bit_v = eb; e.ones = eo; e.unstable = eu;
    e.due = hs + (int'(reps) + 1) * EVAL_CYC;
    exp_q.push_back(e);
  endtask

  task automatic waitIdle(input int hs, input int n_eval, input logic check_pulse);
    int n = 0;
    int k;
    while (!req_ready && n < 400) begin
      @(negedge wb_clk_i);
      n++;
      k = cyc - hs;
      if (k == 0) checkOutput("puf_challenge_c1", 32'(puf_challenge), 32'(req_challenge));
      if (check_pulse && k <= 10)
        checkOutput($sformatf("puf_pulse_c%0d", k + 1), 32'(puf_pulse), 32'(k == 4 || k == 5));
    end
    if (n >= 400) begin
      checks++;
      $display("[TB] FAIL idle_timeout: got req_ready=0 expected 1 within 400 cycles");
    end else begin
      checkOutput("req_ready_return", 32'(cyc - hs), 32'(n_eval * EVAL_CYC + 1));
    end
  endtask

  task automatic applyStimulus(input logic [15:0] chal, input logic [3:0] reps,
                               input logic [15:0] bits, input logic eb,
                               input logic [4:0] eo, input logic eu,
                               input logic check_pulse);
    int hs;
    issueRequest(chal, reps, bits, eb, eo, eu, chal, hs);
    waitIdle(hs, int'(reps) + 1, check_pulse);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs;
    int n;
    logic saw_pulse;
    wb_rst_i = 1'b1; req_valid = 1'b0; req_challenge = '0; req_repeats = '0;
    rsp_ready = 1'b1; puf_response = 1'b0;
`ifdef PUF_SEQ_LFSR_EN
    req_lfsr_mode = 1'b0;
`endif
    repeat (3) @(negedge wb_clk_i);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_puf_pulse", 32'(puf_pulse), 32'd0);
    checkOutput("reset_puf_challenge", 32'(puf_challenge), 32'd0);
    wb_rst_i = 1'b0;

    // chal, repeats, scripted bits (bit i = evaluation i), vote, ones, unstable
    applyStimulus(16'hA5A5, 4'd0,  16'h0001, 1'b1, 5'd1,  1'b0, 1'b1);
    applyStimulus(16'h1234, 4'd4,  16'h000D, 1'b1, 5'd3,  1'b1, 1'b0);
    applyStimulus(16'h0F0F, 4'd3,  16'h0003, 1'b0, 5'd2,  1'b1, 1'b0);
    applyStimulus(16'hFFFF, 4'd2,  16'h0000, 1'b0, 5'd0,  1'b0, 1'b0);
    applyStimulus(16'h8001, 4'd15, 16'hFFFF, 1'b1, 5'd16, 1'b0, 1'b0);
    applyStimulus(16'h0001, 4'd1,  16'h0002, 1'b0, 5'd1,  1'b1, 1'b0);
    applyStimulus(16'h7E7E, 4'd2,  16'h0006, 1'b1, 5'd2,  1'b1, 1'b0);

    // Result held while rsp_ready is low; stray req_valid must be ignored
    rsp_ready = 1'b0;
    issueRequest(16'hC3C3, 4'd2, 16'h0003, 1'b1, 5'd2, 1'b1, 16'hC3C3, hs);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge wb_clk_i); n++; end
    checkOutput("hold_reached_done", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      req_valid     = (i % 4 == 0);
      req_challenge = 16'h1111;
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_bit", 32'(rsp_bit), 32'd1);
      checkOutput("hold_rsp_ones", 32'(rsp_ones), 32'd2);
      checkOutput("hold_rsp_unstable", 32'(rsp_unstable), 32'd1);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      checkOutput("hold_puf_challenge", 32'(puf_challenge), 32'hC3C3);
    end
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("hold_release_ready", 32'(req_ready), 32'd1);
    checkOutput("hold_release_valid", 32'(rsp_valid), 32'd0);
    saw_pulse = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge wb_clk_i);
      if (puf_pulse) saw_pulse = 1'b1;
    end
    checkOutput("no_queued_request", 32'(saw_pulse), 32'd0);

    // Reset asserted while the pulse is high
    resp_q.push_back(1'b1);
    @(negedge wb_clk_i);
    req_challenge = 16'h3C3C; req_repeats = 4'd0; req_valid = 1'b1;
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    n = 0;
    while (!puf_pulse && n < 20) begin @(negedge wb_clk_i); n++; end
    checkOutput("reached_fire", 32'(puf_pulse), 32'd1);
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    checkOutput("midfire_puf_pulse", 32'(puf_pulse), 32'd0);
    checkOutput("midfire_puf_challenge", 32'(puf_challenge), 32'd0);
    checkOutput("midfire_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midfire_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midfire_rsp_ones", 32'(rsp_ones), 32'd0);
    checkOutput("midfire_rsp_bit", 32'(rsp_bit), 32'd0);
    checkOutput("midfire_rsp_unstable", 32'(rsp_unstable), 32'd0);
    wb_rst_i = 1'b0;
    resp_q.delete();
    puf_response = 1'b0;

    applyStimulus(16'h5A5A, 4'd0, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b1);

`ifdef PUF_SEQ_LFSR_EN
    // Two LFSR-mode requests: seed, then one Galois step of the seed
    req_lfsr_mode = 1'b1;
    issueRequest(16'h0000, 4'd0, 16'h0001, 1'b1, 5'd1, 1'b0, 16'hACE1, hs);
    waitIdle(hs, 1, 1'b0);
    issueRequest(16'hFFFF, 4'd0, 16'h0000, 1'b0, 5'd0, 1'b0, 16'hE270, hs);
    waitIdle(hs, 1, 1'b0);
    req_lfsr_mode = 1'b0;
`endif

    repeat (5) @(negedge wb_clk_i);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
